// File: rtl/chan_scan_mux_if.sv
// Channel bus for chan_scan_mux: packed data/select/scan controls in,
// registered selection and status out.
interface chan_scan_mux_if #(
    parameter int N     = 4,
    parameter int W     = 2,
    parameter int SEL_W = 2
);
    logic [N*W-1:0]   data_in;
    logic [SEL_W-1:0] sel;
    logic             mode;
    logic             hold;
    logic             load;
    logic [W-1:0]     m;
    logic [SEL_W-1:0] ch;
    logic             valid;
    logic             wrap;

    modport master (
        output data_in, sel, mode, hold, load,
        input  m, ch, valid, wrap
    );

    modport slave (
        input  data_in, sel, mode, hold, load,
        output m, ch, valid, wrap
    );
endinterface

// File: rtl/chan_scan_mux.sv
// Registered N-channel W-bit multiplexer with manual select or auto-scan
// rotation (programmable dwell, hold, load) and out-of-range detection.
module chan_scan_mux #(
    parameter int N     = 4,
    parameter int W     = 2,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            reset,
    chan_scan_mux_if.slave  bus
);
    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]    N_EXT    = (SEL_W + 1)'(N);
    localparam logic [SEL_W:0]    LAST_EXT = (SEL_W + 1)'(N - 1);

    logic [W-1:0]      m_q;
    logic [SEL_W-1:0]  ch_q;
    logic              valid_q;
    logic              wrap_q;
    logic [DCNT_W-1:0] dcnt;

    logic [SEL_W-1:0]  ch_n;
    logic [DCNT_W-1:0] dcnt_n;
    logic              wrap_n;
    logic [W-1:0]      sel_data;
    logic              sel_ok;
    logic              at_end;
    logic              in_range;

    assign sel_ok   = ({1'b0, bus.sel} < N_EXT);
    // An out-of-range ch left over from manual mode counts as the last channel.
    assign at_end   = ({1'b0, ch_q} >= LAST_EXT);
    assign in_range = ({1'b0, ch_n} < N_EXT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        ch_n   = ch_q;
        dcnt_n = dcnt;
        wrap_n = 1'b0;
        if (!bus.mode) begin
            ch_n   = bus.sel;
            dcnt_n = '0;
        end else if (bus.load) begin
            ch_n   = sel_ok ? bus.sel : '0;
            dcnt_n = '0;
        end else if (bus.hold) begin
            ch_n   = ch_q;
        end else if (dcnt == DCNT_MAX) begin
            dcnt_n = '0;
            if (at_end) begin
                ch_n   = '0;
                wrap_n = 1'b1;
            end else begin
                ch_n   = ch_q + SEL_W'(1);
            end
        end else begin
            dcnt_n = dcnt + DCNT_W'(1);
        end
    end

    // Out-of-range channels match no slice and present zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (ch_n == SEL_W'(k)) begin
                sel_data = bus.data_in[k*W +: W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            dcnt    <= '0;
        end else begin
            m_q     <= sel_data;
            ch_q    <= ch_n;
            valid_q <= in_range;
            wrap_q  <= wrap_n;
            dcnt    <= dcnt_n;
        end
    end

    assign bus.m     = m_q;
    assign bus.ch    = ch_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: N=4/DWELL=4, N=3/DWELL=4 and
// N=4/DWELL=1 instances sharing one clock and reset.
module tb_chan_scan_mux;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [5:0] got, exp_v;

    always #5 clk = ~clk;

    chan_scan_mux_if #(.N(4), .W(2), .SEL_W(2)) b4 ();
    chan_scan_mux_if #(.N(3), .W(2), .SEL_W(2)) b3 ();
    chan_scan_mux_if #(.N(4), .W(2), .SEL_W(2)) b1 ();

    chan_scan_mux #(.N(4), .W(2), .SEL_W(2), .DWELL(4)) d4 (.clk(clk), .reset(reset), .bus(b4.slave));
    chan_scan_mux #(.N(3), .W(2), .SEL_W(2), .DWELL(4)) d3 (.clk(clk), .reset(reset), .bus(b3.slave));
    chan_scan_mux #(.N(4), .W(2), .SEL_W(2), .DWELL(1)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        b4.data_in = '0; b4.sel = '0; b4.mode = 1'b0; b4.hold = 1'b0; b4.load = 1'b0;
        b3.data_in = '0; b3.sel = '0; b3.mode = 1'b0; b3.hold = 1'b0; b3.load = 1'b0;
        b1.data_in = '0; b1.sel = '0; b1.mode = 1'b0; b1.hold = 1'b0; b1.load = 1'b0;
        tick();
        tick();
        got = {b4.m, b4.ch, b4.valid, b4.wrap};
        checks++;
        if (got !== 6'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", got, 6'b0);
        end
        reset = 1'b0;
        tick();
        got = {b4.m, b4.ch, b4.valid, b4.wrap};
        checks++;
        if (got !== 6'b00_00_1_0) begin
            failures++;
            $display("FAIL first_valid got=%b exp=%b", got, 6'b00_00_1_0);
        end
    endtask

    task automatic test_manual;
        b4.data_in = {2'd3, 2'd2, 2'd1, 2'd0};
        b4.mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            b4.sel = 2'(s);
            tick();
            exp_v = {2'(s), 2'(s), 1'b1, 1'b0};
            got = {b4.m, b4.ch, b4.valid, b4.wrap};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL manual sel=%0d got=%b exp=%b", s, got, exp_v);
            end
        end
    endtask

    // ch0=1 ch1=2 ch2=3 ch3=0, so the shown value is (ch+1)%4.
    task automatic test_scan;
        b4.data_in = {2'd0, 2'd3, 2'd2, 2'd1};
        b4.sel = 2'd0;
        tick();
        b4.mode = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            exp_v = {2'((k / 4 + 1) % 4), 2'((k / 4) % 4), 1'b1, (k % 16 == 0)};
            got = {b4.m, b4.ch, b4.valid, b4.wrap};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL scan step=%0d got=%b exp=%b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_hold;
        for (int k = 0; k < 9; k++) tick();
        got = {b4.m, b4.ch, b4.valid, b4.wrap};
        checks++;
        if (got !== 6'b11_10_1_0) begin
            failures++;
            $display("FAIL hold_setup got=%b exp=%b", got, 6'b11_10_1_0);
        end
        b4.hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) b4.data_in[5:4] = 2'd1;
            tick();
            exp_v = {(i >= 3) ? 2'd1 : 2'd3, 2'd2, 1'b1, 1'b0};
            got = {b4.m, b4.ch, b4.valid, b4.wrap};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL hold cycle=%0d got=%b exp=%b", i, got, exp_v);
            end
        end
        b4.hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = (i < 2) ? 6'b01_10_1_0 : 6'b00_11_1_0;
            got = {b4.m, b4.ch, b4.valid, b4.wrap};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL hold_release cycle=%0d got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_load;
        b4.hold = 1'b1;
        b4.load = 1'b1;
        b4.sel = 2'd1;
        tick();
        got = {b4.m, b4.ch, b4.valid, b4.wrap};
        checks++;
        if (got !== 6'b10_01_1_0) begin
            failures++;
            $display("FAIL load_over_hold got=%b exp=%b", got, 6'b10_01_1_0);
        end
        b4.hold = 1'b0;
        b4.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = (i < 3) ? 6'b10_01_1_0 : 6'b01_10_1_0;
            got = {b4.m, b4.ch, b4.valid, b4.wrap};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL load_dwell cycle=%0d got=%b exp=%b", i, got, exp_v);
            end
        end
        b3.data_in = {2'd3, 2'd2, 2'd1};
        b3.mode = 1'b0;
        b3.sel = 2'd1;
        tick();
        b3.mode = 1'b1;
        b3.load = 1'b1;
        b3.sel = 2'd3;
        tick();
        b3.load = 1'b0;
        got = {b3.m, b3.ch, b3.valid, b3.wrap};
        checks++;
        if (got !== 6'b01_00_1_0) begin
            failures++;
            $display("FAIL load_out_of_range got=%b exp=%b", got, 6'b01_00_1_0);
        end
    endtask

    task automatic test_out_of_range;
        b3.mode = 1'b0;
        b3.sel = 2'd2;
        tick();
        got = {b3.m, b3.ch, b3.valid, b3.wrap};
        checks++;
        if (got !== 6'b11_10_1_0) begin
            failures++;
            $display("FAIL n3_last_channel got=%b exp=%b", got, 6'b11_10_1_0);
        end
        b3.sel = 2'd3;
        tick();
        got = {b3.m, b3.ch, b3.valid, b3.wrap};
        checks++;
        if (got !== 6'b00_11_0_0) begin
            failures++;
            $display("FAIL n3_sel3 got=%b exp=%b", got, 6'b00_11_0_0);
        end
        b3.mode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_v = (i < 4) ? 6'b00_11_0_0 : (i == 4) ? 6'b01_00_1_1 : 6'b01_00_1_0;
            got = {b3.m, b3.ch, b3.valid, b3.wrap};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL n3_scan_entry step=%0d got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_dwell1;
        b1.data_in = {2'd3, 2'd2, 2'd1, 2'd0};
        b1.mode = 1'b0;
        b1.sel = 2'd2;
        tick();
        b1.mode = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_v = {2'((2 + i) % 4), 2'((2 + i) % 4), 1'b1, (i == 2)};
            got = {b1.m, b1.ch, b1.valid, b1.wrap};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL dwell1 step=%0d got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_async_reset;
        b4.data_in = {2'd0, 2'd3, 2'd2, 2'd1};
        b4.mode = 1'b0;
        b4.sel = 2'd0;
        tick();
        b4.mode = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        got = {b4.m, b4.ch, b4.valid, b4.wrap};
        checks++;
        if (got !== 6'b0) begin
            failures++;
            $display("FAIL async_reset_immediate got=%b exp=%b", got, 6'b0);
        end
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_v = (i < 4) ? 6'b01_00_1_0 : 6'b10_01_1_0;
            got = {b4.m, b4.ch, b4.valid, b4.wrap};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL post_reset_scan step=%0d got=%b exp=%b", i, got, exp_v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_hold();
        test_load();
        test_out_of_range();
        test_dwell1();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/chan_scan_mux.md
Name: chan_scan_mux

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Successor to the fixed 2-bit 4-to-1 combinational mux.
- Adds a registered output, a manual/auto-scan mode, a programmable dwell time per channel, hold/load controls and out-of-range select detection.
- Sits between the switch/input banks and the display/LED logic so several data sources can be viewed in rotation.

Parameters:
N, 4, number of input channels (>=2)
W, 2, bits per channel
SEL_W, 2, select/channel-index width; must satisfy 2^SEL_W >= N
DWELL, 4, clock cycles spent on each channel in scan mode (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  N*W  packed channels; channel k = data_in[k*W+W-1 : k*W]
sel  input  SEL_W  manual channel select; also the scan start channel on load
mode  input  1  0 = manual, 1 = auto-scan
hold  input  1  scan mode only: freeze channel index and dwell counter
load  input  1  scan mode only: jump to channel sel, restart dwell
m  output  W  registered selected data
ch  output  SEL_W  channel index currently presented on m
valid  output  1  1 when ch < N and m holds real channel data
wrap  output  1  one-cycle pulse when scan steps from channel N-1 to 0

Behaviour:
- Reset (asynchronous, active-high): m=0, ch=0, valid=0, wrap=0, internal dwell counter dcnt=0. Reset takes effect immediately, including mid-dwell; no state survives it.
- Next channel ch_n is computed combinationally each cycle. On the edge, ch<=ch_n and m<=slice(data_in, ch_n).
  - m and ch always describe the same channel.
  - Latency: m reflects data_in exactly one cycle after it is sampled.
- Manual mode (mode=0):
  - ch_n=sel.
  - dcnt<=0, wrap<=0.
  - hold and load are ignored.
- Scan mode (mode=1), conditions in priority order:
  1. load=1: if sel<N then ch_n=sel, else ch_n=0. dcnt<=0; wrap<=0. Load overrides hold.
  2. hold=1: ch_n=ch; dcnt unchanged; wrap<=0. m continues to track the live data of channel ch.
  3. dcnt==DWELL-1: dcnt<=0 and ch_n=(ch==N-1)?0:ch+1. wrap<=1 only when ch==N-1.
  4. Otherwise: dcnt<=dcnt+1; ch_n=ch; wrap<=0.
- Each channel is shown for exactly DWELL cycles when hold and load stay low.
- DWELL=1 advances the channel every cycle.
- Mode switch manual->scan: scanning starts at the current ch with dcnt=0.
- Mode switch scan->manual: ch follows sel on the next edge.
- If ch>=N (possible in manual mode when N is not a power of 2) when scan mode is entered: treat as ch==N-1, so the next step wraps to 0 and asserts wrap.
- Out-of-range select (ch_n>=N): m<=0, valid<=0, ch<=ch_n. In-range: valid<=1. valid is first 1 on the first edge after reset is released (ch_n=0 or sel).
- dcnt width is clog2(DWELL) bits, minimum 1. No other arithmetic; all counters wrap explicitly, never by overflow.

Test Plan:
1. N=4, W=2, mode=0, channels {3,2,1,0} (ch0=0 ... ch3=3), sel stepped 0..3 one per cycle -> m=0,1,2,3 each one cycle after sel; ch==sel; valid=1; wrap=0.
2. mode=1, DWELL=4, channels {ch0=1, ch1=2, ch2=3, ch3=0} -> m holds 1,2,3,0 for 4 cycles each. wrap pulses for exactly 1 cycle as ch goes 3->0. The sequence repeats with period 16 cycles.
3. Scan mode, hold=1 for 6 cycles at ch=2, dcnt=1 -> ch stays 2. Changing ch2 data to 1 shows m=1 the next cycle. After hold drops, ch advances after 2 more cycles.
4. Scan mode, load=1 with sel=1 while hold=1 -> ch=1 next cycle, dcnt=0. Load with sel=3 when N=3 -> ch=0, valid=1.
5. N=3, SEL_W=2, mode=0, sel=3 -> m=0, valid=0, ch=3. Switching to mode=1 -> next step ch=0 with wrap=1.
6. Reset asserted asynchronously mid-dwell in scan mode (between edges) -> m=0, ch=0, valid=0, wrap=0 immediately. After release: scanning restarts at ch0 with a full DWELL period.
